// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD encoder request arbiter.
package bcd_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } arb_state_t;

  localparam logic [15:0] BCD_MAX = 16'd9999;  // largest operand the encoder is asked to convert
  localparam logic [15:0] BCD_SAT = 16'h9999;  // saturated result for out-of-range operands

  // Width of a counter that must hold 0..t-1.
  function automatic int cnt_w(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/bcd_request_arbiter_rr_arbiter.sv
// Round-robin picker: first set request strictly after the pointer, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_id
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;
  int              w_sum;

  // Scan pointer+1 .. pointer+NUM_REQ modulo NUM_REQ, take the first hit.
  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = ID_W'(w_sum);
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/bcd_request_arbiter.sv
// Shares one bit-serial binary-to-BCD encoder between NUM_REQ requesters.
module bcd_request_arbiter
  import bcd_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*16-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [15:0]           o_rsp_bcd,
  output logic                  o_rsp_ovf,
  output logic                  o_rsp_err,
  output logic                  o_busy,
  output logic                  o_err,
  output logic                  o_enc_begin,
  output logic [15:0]           o_enc_binary,
  input  logic                  i_enc_done,
  input  logic [15:0]           i_enc_bcd
);

  localparam int            CW       = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t                 r_state, w_state_nxt;
  logic [ID_W-1:0]            r_ptr, w_ptr_nxt, r_id, w_id_nxt;
  logic [CW-1:0]              r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]         r_gnt, w_gnt_nxt;
  logic [15:0]                r_op, w_op_nxt, r_bcd, w_bcd_nxt;
  logic                       r_ovf, w_ovf_nxt, r_err, w_err_nxt, r_sticky, w_sticky_nxt;
  logic [NUM_REQ-1:0]         w_arb_gnt;
  logic [ID_W-1:0]            w_arb_id;
  logic [NUM_REQ-1:0][15:0]   w_data;
  logic                       w_resp;

  assign w_data = i_req_data;

  // Only arbitrate while idle and the encoder is free.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .i_en  ((r_state == S_IDLE) && i_enc_done),
    .o_gnt (w_arb_gnt),
    .o_id  (w_arb_id)
  );

  // Next-state and datapath decode for the transaction sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_id_nxt     = r_id;
    w_cnt_nxt    = r_cnt;
    w_gnt_nxt    = '0;
    w_op_nxt     = r_op;
    w_bcd_nxt    = r_bcd;
    w_ovf_nxt    = r_ovf;
    w_err_nxt    = r_err;
    w_sticky_nxt = r_sticky;
    case (r_state)
      S_IDLE: if (|w_arb_gnt) begin
        w_gnt_nxt   = w_arb_gnt;
        w_id_nxt    = w_arb_id;
        w_op_nxt    = w_data[w_arb_id];
        w_bcd_nxt   = '0;
        w_ovf_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (r_op > BCD_MAX) begin
        w_ovf_nxt   = 1'b1;
        w_bcd_nxt   = BCD_SAT;
        w_state_nxt = S_RESP;
      end else begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!i_enc_done) begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_DONE;
      end else if (r_cnt == CNT_LAST) begin
        w_err_nxt   = 1'b1;
        w_bcd_nxt   = '0;
        w_state_nxt = S_RESP;
      end else begin
        w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_WAIT_DONE: if (i_enc_done) begin
        w_bcd_nxt   = i_enc_bcd;
        w_state_nxt = S_RESP;
      end else if (r_cnt == CNT_LAST) begin
        w_err_nxt   = 1'b1;
        w_bcd_nxt   = '0;
        w_state_nxt = S_RESP;
      end else begin
        w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_RESP: begin
        w_ptr_nxt    = r_id;
        w_sticky_nxt = r_sticky | r_err;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= ID_W'(NUM_REQ - 1);
      r_id     <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_op     <= '0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_id     <= w_id_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_op     <= w_op_nxt;
      r_bcd    <= w_bcd_nxt;
      r_ovf    <= w_ovf_nxt;
      r_err    <= w_err_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign w_resp       = (r_state == S_RESP);
  assign o_gnt        = r_gnt;
  assign o_busy       = (r_state != S_IDLE);
  assign o_rsp_valid  = w_resp;
  assign o_rsp_id     = w_resp ? r_id  : '0;
  assign o_rsp_bcd    = w_resp ? r_bcd : '0;
  assign o_rsp_ovf    = w_resp & r_ovf;
  assign o_rsp_err    = w_resp & r_err;
  assign o_err        = r_sticky;
  assign o_enc_begin  = (r_state == S_ISSUE) && (r_op <= BCD_MAX);
  assign o_enc_binary = r_op;

endmodule

// File: tb/tb_bcd_request_arbiter.sv
// Randomised + directed bench for bcd_request_arbiter against a behavioural model.
module tb_bcd_request_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [15:0]     data [N];
  logic [N*16-1:0] req_data;
  logic [N-1:0]    o_gnt;
  logic            o_rsp_valid, o_rsp_ovf, o_rsp_err, o_busy, o_err, o_enc_begin;
  logic [1:0]      o_rsp_id;
  logic [15:0]     o_rsp_bcd, o_enc_binary;
  logic            enc_done;
  logic            e_done;
  logic [15:0]     e_bcd, e_val;
  int              e_cnt;
  bit              enc_stuck = 0, enc_busy = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int k = 0; k < N; k++) req_data[k*16 +: 16] = data[k];
  end

  bcd_request_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_bcd(o_rsp_bcd),
    .o_rsp_ovf(o_rsp_ovf), .o_rsp_err(o_rsp_err), .o_busy(o_busy), .o_err(o_err),
    .o_enc_begin(o_enc_begin), .o_enc_binary(o_enc_binary),
    .i_enc_done(enc_done), .i_enc_bcd(e_bcd)
  );

  function automatic logic [15:0] to_bcd(input logic [15:0] v);
    int x;
    x = int'(v);
    return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  // Encoder model: done drops the cycle after begin, rises 16 cycles later.
  assign enc_done = e_done & ~enc_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_done <= 1'b1; e_cnt <= 0; e_bcd <= 16'hDEAD; e_val <= '0;
    end else if (e_cnt > 0) begin
      e_cnt <= e_cnt - 1;
      if (e_cnt == 1) begin e_done <= 1'b1; e_bcd <= to_bcd(e_val); end
    end else if (o_enc_begin && !enc_stuck) begin
      e_done <= 1'b0; e_cnt <= 16; e_val <= o_enc_binary; e_bcd <= 16'hDEAD;
    end
  end

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_rsp = 0, last_rsp_cyc = 0;
  int m_ptr = N - 1;
  bit m_err = 0;
  bit inf = 0;
  int inf_id = 0, inf_gcyc = 0;
  logic [15:0] inf_op = '0;
  bit inf_stuck = 0;
  int rsp_ids [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, o_gnt, 0);
    chk({tag, "_vld"}, o_rsp_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_beg"}, o_enc_begin, 0);
    chk({tag, "_bin"}, o_enc_binary, 0);
    chk({tag, "_bcd"}, o_rsp_bcd, 0);
  endtask

  // One clock: sample #1 after the edge, then compare against the model.
  task automatic step();
    int e, lat;
    logic [15:0] ebcd;
    bit eovf, eerr;
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin
      chk("rst_novld", o_rsp_valid, 0);
      return;
    end
    if (o_gnt != '0) begin
      e = rr_pick(req, m_ptr);
      chk("gnt", o_gnt, (e < 0) ? 0 : (1 << e));
      chk("gnt_single_flight", inf, 0);
      if (e >= 0) begin
        inf = 1; inf_id = e; inf_op = data[e]; inf_stuck = enc_stuck; inf_gcyc = cyc;
        req[e] = 1'b0;
      end
    end
    if (o_enc_begin) begin
      chk("begin_ok", (inf && inf_op <= 16'd9999 && cyc == inf_gcyc), 1);
      chk("enc_bin", o_enc_binary, inf_op);
    end
    chk("o_err", o_err, m_err);
    if (o_rsp_valid) begin
      chk("rsp_expected", inf, 1);
      if (inf) begin
        eovf = inf_op > 16'd9999;
        eerr = !eovf && inf_stuck;
        ebcd = eovf ? 16'h9999 : (eerr ? 16'h0000 : to_bcd(inf_op));
        lat  = eovf ? 1 : (eerr ? TO + 1 : 18);
        chk("rsp_id", o_rsp_id, inf_id);
        chk("rsp_bcd", o_rsp_bcd, ebcd);
        chk("rsp_ovf", o_rsp_ovf, eovf);
        chk("rsp_err", o_rsp_err, eerr);
        chk("rsp_lat", cyc - inf_gcyc, lat);
        m_ptr = inf_id;
        if (eerr) m_err = 1;
        rsp_ids.push_back(inf_id);
        inf = 0; n_rsp++; last_rsp_cyc = cyc;
      end
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int b = 0;
    while (n_rsp < target && b < budget) begin step(); b++; end
    chk("wait_rsp", n_rsp >= target, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req = '0;
    inf = 0; m_ptr = N - 1; m_err = 0;
    #1;
    chk_zero("rst");
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic put(input int k, input logic [15:0] v);
    data[k] = v; req[k] = 1'b1;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 9))
      0: return 16'd0;
      1: return 16'd9999;
      2: return 16'd10000;
      3: return 16'hFFFF;
      default: return 16'($urandom_range(0, 9999));
    endcase
  endfunction

  initial begin
    int rq, g, b;
    for (int k = 0; k < N; k++) data[k] = '0;
    reset_dut();
    step();

    // Single request
    put(0, 16'd1234); rq = cyc;
    wait_rsp(n_rsp + 1, 40);
    chk("lat_single", last_rsp_cyc - rq, 19);
    step(); chk("idle_busy", o_busy, 0);

    // Contention from reset pointer, then wrap-around search
    reset_dut(); step();
    rsp_ids.delete();
    put(0, 16'd5); put(1, 16'd42); put(2, 16'd999); put(3, 16'd9999);
    wait_rsp(n_rsp + 4, 120);
    put(3, 16'd3); put(1, 16'd1);
    wait_rsp(n_rsp + 2, 60);
    chk("order_len", rsp_ids.size(), 6);
    if (rsp_ids.size() == 6) begin
      chk("order0", rsp_ids[0], 0); chk("order1", rsp_ids[1], 1);
      chk("order2", rsp_ids[2], 2); chk("order3", rsp_ids[3], 3);
      chk("order4", rsp_ids[4], 1); chk("order5", rsp_ids[5], 3);
    end

    // Overflow saturation
    put(2, 16'd10000); wait_rsp(n_rsp + 1, 20);
    put(2, 16'hFFFF);  wait_rsp(n_rsp + 1, 20);

    // Stuck encoder: done stays high after begin
    enc_stuck = 1;
    put(0, 16'd4242); wait_rsp(n_rsp + 1, 120);
    enc_stuck = 0;
    step(); chk("sticky_err", o_err, 1);
    put(3, 16'd0); wait_rsp(n_rsp + 1, 40);

    // Reset in the 8th cycle of WAIT_DONE
    put(1, 16'd4321);
    b = 0;
    while (!inf && b < 20) begin step(); b++; end
    chk("rst_test_gnt", inf, 1);
    g = inf_gcyc;
    while (cyc < g + 9 && b < 40) begin step(); b++; end
    #3 rst_n = 1'b0; req = '0; inf = 0; m_ptr = N - 1; m_err = 0;
    #1 chk_zero("midrst");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    put(1, 16'd77); wait_rsp(n_rsp + 1, 40);

    // Encoder busy when the request arrives
    enc_busy = 1;
    put(0, 16'd8765);
    repeat (6) begin step(); chk("no_gnt_busy", o_gnt, 0); end
    enc_busy = 0; rq = cyc;
    wait_rsp(n_rsp + 1, 40);
    chk("lat_busy", last_rsp_cyc - rq, 19);

    // Randomised traffic with drop-outs
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < N; k++)
          if (!req[k] && $urandom_range(0, 2) == 0) put(k, rand_op());
      if ($urandom_range(0, 15) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
      step();
    end
    req = '0;
    if (inf) wait_rsp(n_rsp + 1, 40);
    step(); chk("final_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
